// File: rtl/sevenseg_pkg.sv
// Shared definitions for the BCD seven-segment scanner: segment patterns,
// FSM state encoding and the nibble-to-segment lookup.
package sevenseg_pkg;

   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;

   typedef enum logic {
      S_IDLE,
      S_SCAN
   } state_t;

   // Nibbles A-F are not valid BCD, so they show a lone middle bar.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
      logic [6:0] seg;
      case (nibble)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/bcd_sevenseg_scan_seg7_decode.sv
// Combinational decoder from one BCD nibble to active-high a..g segments.
module seg7_decode
   import sevenseg_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   assign o_seg = bcd_to_seg(i_nibble);

endmodule

// File: rtl/bcd_sevenseg_scan.sv
// Time-multiplexed seven-segment driver with frame-aligned value updates.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module bcd_sevenseg_scan
   import sevenseg_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 1000
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_bcd_valid,
   input  logic [4*DIGITS-1:0]   i_bcd,
   input  logic                  i_blank,
   output logic [6:0]            o_seg,
   output logic [DIGITS-1:0]     o_dig_en,
   output logic                  o_frame_done,
   output logic                  o_pending
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PRE_W = $clog2(PRESCALE);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
   localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(PRESCALE - 1);

   state_t             state_q,      state_d;
   logic [PRE_W-1:0]   presc_q,      presc_d;
   logic [IDX_W-1:0]   index_q,      index_d;
   logic [BCD_W-1:0]   disp_q,       disp_d;
   logic [BCD_W-1:0]   pend_data_q,  pend_data_d;
   logic               pend_q,       pend_d;
   logic [6:0]         seg_q,        seg_d;
   logic [DIGITS-1:0]  dig_en_q,     dig_en_d;
   logic               frame_done_q, frame_done_d;

   logic               tick;
   logic               boundary;
   logic [3:0]         cur_nibble;
   logic [6:0]         dec_seg;
   logic               lz_blank;

   assign tick       = (state_q == S_SCAN) && (presc_q == LAST_PRE);
   assign boundary   = tick && (index_q == LAST_IDX);
   assign cur_nibble = disp_q[{index_q, 2'b00} +: 4];

   seg7_decode u_decode (
      .i_nibble (cur_nibble),
      .o_seg    (dec_seg)
   );

`ifdef LEADING_ZERO_BLANK_EN
   // A digit is a leading zero when it and every more-significant nibble are 0.
   always_comb begin
      lz_blank = (index_q != '0) && ((disp_q >> {index_q, 2'b00}) == '0);
   end
`else
   assign lz_blank = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= S_IDLE;
         presc_q      <= '0;
         index_q      <= '0;
         disp_q       <= '0;
         pend_data_q  <= '0;
         pend_q       <= 1'b0;
         seg_q        <= '0;
         dig_en_q     <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         index_q      <= index_d;
         disp_q       <= disp_d;
         pend_data_q  <= pend_data_d;
         pend_q       <= pend_d;
         seg_q        <= seg_d;
         dig_en_q     <= dig_en_d;
         frame_done_q <= frame_done_d;
      end
   end

   // New values only reach the display register at a frame boundary,
   // except for the very first capture which starts the scan.
   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      index_d     = index_q;
      disp_d      = disp_q;
      pend_data_d = pend_data_q;
      pend_d      = pend_q;
      case (state_q)
         S_IDLE: begin
            if (i_bcd_valid) begin
               state_d = S_SCAN;
               disp_d  = i_bcd;
               presc_d = '0;
               index_d = '0;
               pend_d  = 1'b0;
            end
         end
         S_SCAN: begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
               index_d = (index_q == LAST_IDX) ? '0 : index_q + 1'b1;
            end
            if (boundary) begin
               if (i_bcd_valid) begin
                  disp_d = i_bcd;
                  pend_d = 1'b0;
               end else if (pend_q) begin
                  disp_d = pend_data_q;
                  pend_d = 1'b0;
               end
            end else if (i_bcd_valid) begin
               pend_data_d = i_bcd;
               pend_d      = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      seg_d        = '0;
      dig_en_d     = '0;
      frame_done_d = 1'b0;
      if (state_q == S_SCAN) begin
         seg_d        = lz_blank ? 7'h00 : dec_seg;
         dig_en_d     = i_blank ? '0 : (DIGITS'(1) << index_q);
         frame_done_d = boundary;
      end
   end

   assign o_seg        = seg_q;
   assign o_dig_en     = dig_en_q;
   assign o_frame_done = frame_done_q;
   assign o_pending    = pend_q;

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Self-checking bench for bcd_sevenseg_scan: directed scenarios plus random
// captures, checked each cycle against a frame-arithmetic reference model.
module tb_bcd_sevenseg_scan;

   localparam int DIGITS   = 4;
   localparam int PRESCALE = 4;
   localparam int FRAME    = DIGITS * PRESCALE;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        bcd_valid = 1'b0;
   logic [15:0] bcd = '0;
   logic        blank = 1'b0;
   logic [6:0]  seg;
   logic [3:0]  dig_en;
   logic        frame_done;
   logic        pending;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Reference model: the scan position is derived from edges elapsed since
   // the first capture, not from any prescaler or index register.
   bit          m_scan  = 0;
   int          m_k     = 0;
   logic [15:0] m_disp  = '0;
   logic [15:0] m_pend  = '0;
   bit          m_pflag = 0;
   logic [6:0]  exp_seg = '0;
   logic [3:0]  exp_en  = '0;
   logic        exp_fd  = 1'b0;
   logic        exp_pend = 1'b0;
   logic [6:0]  seg_rom [16];

   bcd_sevenseg_scan #(
      .DIGITS   (DIGITS),
      .PRESCALE (PRESCALE)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_bcd_valid  (bcd_valid),
      .i_bcd        (bcd),
      .i_blank      (blank),
      .o_seg        (seg),
      .o_dig_en     (dig_en),
      .o_frame_done (frame_done),
      .o_pending    (pending)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] refSeg(input logic [15:0] value, input int digit);
      logic [3:0] nib;
      nib = value[digit*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      if (digit > 0 && (value >> (4 * digit)) == 16'h0) return 7'h00;
`endif
      return seg_rom[nib];
   endfunction

   task automatic applyStimulus(input logic v, input logic [15:0] b, input logic bl);
      bcd_valid = v;
      bcd       = b;
      blank     = bl;
   endtask

   task automatic compareVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      assert (obs === exp) else begin
         n_mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      m_scan   = 0;
      m_k      = 0;
      m_disp   = '0;
      m_pflag  = 0;
      exp_seg  = '0;
      exp_en   = '0;
      exp_fd   = 1'b0;
      exp_pend = 1'b0;
   endtask

   task automatic modelEdge();
      int idx;
      bit bnd;
      if (rst) begin
         modelReset();
         return;
      end
      if (!m_scan) begin
         exp_seg = '0;
         exp_en  = '0;
         exp_fd  = 1'b0;
         if (bcd_valid) begin
            m_scan  = 1;
            m_k     = 0;
            m_disp  = bcd;
            m_pflag = 0;
         end
      end else begin
         idx     = (m_k / PRESCALE) % DIGITS;
         bnd     = (m_k % FRAME) == FRAME - 1;
         exp_en  = blank ? 4'b0000 : (4'b0001 << idx);
         exp_seg = refSeg(m_disp, idx);
         exp_fd  = bnd;
         if (bnd) begin
            if (bcd_valid) begin
               m_disp  = bcd;
               m_pflag = 0;
            end else if (m_pflag) begin
               m_disp  = m_pend;
               m_pflag = 0;
            end
         end else if (bcd_valid) begin
            m_pend  = bcd;
            m_pflag = 1;
         end
         m_k++;
      end
      exp_pend = m_pflag;
   endtask

   task automatic checkOutput(input string tag);
      compareVal({tag, "_seg"},     seg,        exp_seg);
      compareVal({tag, "_dig_en"},  dig_en,     exp_en);
      compareVal({tag, "_frame"},   frame_done, exp_fd);
      compareVal({tag, "_pending"}, pending,    exp_pend);
   endtask

   task automatic cycle();
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput("cyc");
   endtask

   task automatic idleCycles(input int n);
      applyStimulus(1'b0, 16'h0, blank);
      repeat (n) cycle();
   endtask

   task automatic pulse(input logic [15:0] value);
      applyStimulus(1'b1, value, blank);
      cycle();
      applyStimulus(1'b0, 16'h0, blank);
   endtask

   // Advance until the next edge is the given position within a frame.
   task automatic waitPhase(input int ph);
      int budget;
      budget = 2 * FRAME;
      while (!(m_scan && (m_k % FRAME) == ph) && budget > 0) begin
         cycle();
         budget--;
      end
      if (budget == 0) begin
         n_compared++;
         n_mismatched++;
         $error("[TB] FAIL waitPhase: observed timeout expected phase %0d", ph);
      end
   endtask

   initial begin
      seg_rom = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
      applyStimulus(1'b0, 16'h0, 1'b0);
      rst = 1'b1;
      #1;
      compareVal("reset_seg", seg, 7'h00);
      compareVal("reset_en", dig_en, 4'h0);
      repeat (3) cycle();
      #2 rst = 1'b0;
      idleCycles(3);

      $display("[TB] first capture 0218");
      pulse(16'h0218);
      compareVal("idle_capture_en", dig_en, 4'b0000);
      cycle();
      compareVal("first_digit_en", dig_en, 4'b0001);
      compareVal("first_digit_seg", seg, 7'h7F);
      idleCycles(40);

      $display("[TB] mid-frame update 9999");
      waitPhase(5);
      pulse(16'h9999);
      compareVal("pending_set", pending, 1);
      idleCycles(40);

      $display("[TB] last write wins");
      waitPhase(2);
      pulse(16'h1111);
      idleCycles(3);
      pulse(16'h2222);
      idleCycles(40);

      $display("[TB] invalid nibbles 00AF");
      pulse(16'h00AF);
      idleCycles(40);

      $display("[TB] capture on frame boundary");
      waitPhase(FRAME - 1);
      pulse(16'h4567);
      compareVal("boundary_no_pending", pending, 0);
      idleCycles(20);

      $display("[TB] blanking");
      applyStimulus(1'b0, 16'h0, 1'b1);
      repeat (20) cycle();
      applyStimulus(1'b0, 16'h0, 1'b0);
      repeat (20) cycle();

      $display("[TB] random captures");
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'b0, 16'h0, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 24)) cycle();
         pulse(16'($urandom));
      end
      applyStimulus(1'b0, 16'h0, 1'b0);
      idleCycles(20);

      $display("[TB] reset with value pending");
      waitPhase(6);
      pulse(16'h3141);
      compareVal("pre_reset_pending", pending, 1);
      #2 rst = 1'b1;
      #1;
      modelReset();
      compareVal("async_seg", seg, 7'h00);
      compareVal("async_en", dig_en, 4'h0);
      compareVal("async_frame", frame_done, 0);
      compareVal("async_pending", pending, 0);
      repeat (2) cycle();
      #2 rst = 1'b0;
      idleCycles(20);
      compareVal("dark_after_reset", dig_en, 4'h0);
      pulse(16'h8888);
      idleCycles(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
